// File: rtl/movegen_sequencer_if.sv
// Signal bundle between movegen_sequencer and its environment: pass control,
// the eight column FIFO ports and the outgoing valid/ready move stream.
interface movegen_sequencer_if #(
    parameter int NCOL = 8,
    parameter int FW   = 160
);
    logic                 start;
    logic                 busy;
    logic                 col_reset;
    logic [NCOL-1:0]      col_done;
    logic [NCOL-1:0]      col_empty;
    logic [NCOL-1:0]      col_rden;
    logic [NCOL*FW-1:0]   col_data;
    logic                 mv_valid;
    logic                 mv_ready;
    logic [FW-1:0]        mv_data;
    logic [2:0]           mv_col;
    logic [7:0]           mv_count;
    logic                 scan_done;
    logic                 timeout;

    modport master (
        input  start, col_done, col_empty, col_data, mv_ready,
        output busy, col_reset, col_rden, mv_valid, mv_data, mv_col,
               mv_count, scan_done, timeout
    );

    modport slave (
        output start, col_done, col_empty, col_data, mv_ready,
        input  busy, col_reset, col_rden, mv_valid, mv_data, mv_col,
               mv_count, scan_done, timeout
    );
endinterface

// File: rtl/movegen_sequencer.sv
// One move-generation pass: reset the columns, wait for done, drain the column FIFOs
// into a registered move stream. Define MOVEGEN_FIXED_PRIO_EN for lowest-index-first grant.
module movegen_sequencer #(
    parameter int NCOL    = 8,
    parameter int FW      = 160,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    movegen_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_RST, S_WAIT, S_DRAIN, S_FIN} state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            mv_valid_q, mv_valid_d;
    logic [FW-1:0]   mv_data_q, mv_data_d;
    logic [2:0]      mv_col_q, mv_col_d;
    logic [7:0]      mv_count_q, mv_count_d;
    logic            timeout_q, timeout_d;
    logic [NCOL-1:0] rden;
    logic [2:0]      grant;
    logic            any_ne;
    logic            out_free;

    assign any_ne   = ~&bus.col_empty;
    assign out_free = !mv_valid_q || bus.mv_ready;

`ifdef MOVEGEN_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (!bus.col_empty[i]) grant = 3'(i);
        end
    end
`else
    logic [2:0] rr_q, rr_d;
    logic       found;

    // Search starts at the rr pointer and wraps, so every column gets a turn.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NCOL; i++) begin
            if (!found && !bus.col_empty[(int'(rr_q) + i) % NCOL]) begin
                grant = 3'((int'(rr_q) + i) % NCOL);
                found = 1'b1;
            end
        end
    end
`endif

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mv_valid_d = mv_valid_q;
        mv_data_d  = mv_data_q;
        mv_col_d   = mv_col_q;
        mv_count_d = mv_count_q;
        timeout_d  = timeout_q;
        rden       = '0;
`ifndef MOVEGEN_FIXED_PRIO_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_RST;
                    cnt_d      = '0;
                    mv_count_d = '0;
                    timeout_d  = 1'b0;
`ifndef MOVEGEN_FIXED_PRIO_EN
                    rr_d       = '0;
`endif
                end
            end
            S_RST: begin
                if (cnt_q == 8'(RST_CYC - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (&bus.col_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = S_DRAIN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (out_free) begin
                    if (any_ne) begin
                        rden[grant] = 1'b1;
                        mv_valid_d  = 1'b1;
                        mv_data_d   = bus.col_data[int'(grant)*FW +: FW];
                        mv_col_d    = grant;
                        mv_count_d  = (mv_count_q == 8'hFF) ? mv_count_q : mv_count_q + 8'd1;
`ifndef MOVEGEN_FIXED_PRIO_EN
                        rr_d        = (int'(grant) == NCOL - 1) ? 3'd0 : grant + 3'd1;
`endif
                    end else begin
                        mv_valid_d = 1'b0;
                    end
                end
                // An empty FIFO set means no pop this cycle, so only the register matters.
                if (!any_ne && !mv_valid_q) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mv_valid_q <= 1'b0;
            mv_data_q  <= '0;
            mv_col_q   <= '0;
            mv_count_q <= '0;
            timeout_q  <= 1'b0;
`ifndef MOVEGEN_FIXED_PRIO_EN
            rr_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mv_valid_q <= mv_valid_d;
            mv_data_q  <= mv_data_d;
            mv_col_q   <= mv_col_d;
            mv_count_q <= mv_count_d;
            timeout_q  <= timeout_d;
`ifndef MOVEGEN_FIXED_PRIO_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.col_reset = (state_q == S_RST);
    assign bus.scan_done = (state_q == S_FIN);
    assign bus.col_rden  = rden;
    assign bus.mv_valid  = mv_valid_q;
    assign bus.mv_data   = mv_data_q;
    assign bus.mv_col    = mv_col_q;
    assign bus.mv_count  = mv_count_q;
    assign bus.timeout   = timeout_q;
endmodule
